// File: rtl/lcd_pkg.sv
// Shared state type, default phase timing and parameter sanity helper for
// the LCD strobe generator.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } lcd_state_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 13;
    localparam int DEF_HOLD_CYC  = 1;
    localparam int DEF_CNT_W     = 8;

    // A phase length is usable when it is at least one cycle and representable in the counter.
    function automatic bit cyc_fits(input int cyc, input int cnt_w);
        return (cyc >= 1) && (longint'(cyc) < (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/lcd_strobe_gen_if.sv
// Request/strobe bundle between a write requester (master) and the LCD
// strobe generator (slave).
interface lcd_strobe_gen_if
    import lcd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              start;
    logic              rs_in;
    logic [DATA_W-1:0] data_in;
    logic              lcd_rs;
    logic [DATA_W-1:0] lcd_data;
    logic              enable;
    logic              busy;
    logic              done;

    modport master (
        output start, rs_in, data_in,
        input  lcd_rs, lcd_data, enable, busy, done
    );

    modport slave (
        input  start, rs_in, data_in,
        output lcd_rs, lcd_data, enable, busy, done
    );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one FSM phase; it parks at zero and
// flags both "now zero" and "one cycle left".
module lcd_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero,
    output logic             one
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == CNT_ONE);

endmodule

// File: rtl/lcd_strobe_gen.sv
// LCD write strobe generator: SETUP -> PULSE -> HOLD sequencing with registered
// outputs. Define LCD_STROBE_PENDING_EN to queue one write issued while busy.
module lcd_strobe_gen
    import lcd_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    lcd_strobe_gen_if.slave bus
);

    if (!cyc_fits(SETUP_CYC, CNT_W) || !cyc_fits(PULSE_CYC, CNT_W) ||
        !cyc_fits(HOLD_CYC, CNT_W)) begin : g_bad_timing
        $error("lcd_strobe_gen: phase lengths must be >= 1 and fit in CNT_W bits");
    end

    // The counter runs from N-1 down to 0, so each phase spans exactly N cycles.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam bit               HOLD_ONE = (HOLD_CYC == 1);

    lcd_state_e        state_q, state_d;
    logic              rs_q, rs_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              enable_q, enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;
    logic              tmr_one;

    logic              pend_valid;
    logic              pend_rs;
    logic [DATA_W-1:0] pend_data;
    logic              chain_start;

    lcd_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero),
        .one      (tmr_one)
    );

`ifdef LCD_STROBE_PENDING_EN
    logic              pend_valid_q, pend_valid_d;
    logic              pend_rs_q, pend_rs_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              pend_take;

    // Any exit from the last HOLD cycle consumes the slot, whether it chains from
    // the slot or straight from a start arriving in that same cycle.
    assign pend_take = (state_q == ST_HOLD) && tmr_zero;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_rs_d    = pend_rs_q;
        pend_data_d  = pend_data_q;
        if (pend_take) begin
            pend_valid_d = 1'b0;
        end else if (bus.start && busy_q && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_rs_d    = bus.rs_in;
            pend_data_d  = bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_rs_q    <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_rs_q    <= pend_rs_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign pend_valid  = pend_valid_q;
    assign pend_rs     = pend_rs_q;
    assign pend_data   = pend_data_q;
    assign chain_start = bus.start;
`else
    assign pend_valid  = 1'b0;
    assign pend_rs     = 1'b0;
    assign pend_data   = '0;
    assign chain_start = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        rs_d     = rs_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rs_d     = bus.rs_in;
                    data_d   = bus.data_in;
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    if (pend_valid) begin
                        rs_d     = pend_rs;
                        data_d   = pend_data;
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end else if (chain_start) begin
                        rs_d     = bus.rs_in;
                        data_d   = bus.data_in;
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        enable_d = (state_d == ST_PULSE);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_HOLD) && (tmr_load ? HOLD_ONE : tmr_one);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q  <= ST_IDLE;
            rs_q     <= 1'b0;
            data_q   <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_data = data_q;
    assign bus.enable   = enable_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
